uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_cfg.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity-mode codes.
// The TX side imports the same package.
package uart_pkg;

    localparam int NB_STATE = 3;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_mode_e;

    function automatic logic parity_enabled(input parity_mode_e m);
        return (m == PAR_EVEN) || (m == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops reset to RESET_VAL so an idle-high line looks idle out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime-selectable data width, parity and stop bits.
// Frame configuration is captured at the start edge and held for the whole frame.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA       = 8,
    parameter int N_TICKS       = 16,
    parameter int NB_TICK_COUNT = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    input  logic [3:0]         i_nb_data,
    input  logic [1:0]         i_parity_mode,
    input  logic               i_stop2,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done_tick,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam logic [NB_TICK_COUNT-1:0] TICK_HALF = NB_TICK_COUNT'(N_TICKS/2 - 1);
    localparam logic [NB_TICK_COUNT-1:0] TICK_FULL = NB_TICK_COUNT'(N_TICKS - 1);
    localparam logic [3:0]               NB_MAX    = 4'(NB_DATA);

    logic rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    uart_state_e              state_q,  state_d;
    logic [NB_TICK_COUNT-1:0] s_q,      s_d;
    logic [3:0]               n_q,      n_d;
    logic [NB_DATA-1:0]       b_q,      b_d;
    logic [3:0]               nb_q,     nb_d;
    parity_mode_e             pmode_q,  pmode_d;
    logic                     stop2_q,  stop2_d;
    logic                     stopn_q,  stopn_d;
    logic                     perr_q,   perr_d;
    logic                     ferr_q,   ferr_d;
    logic [NB_DATA-1:0]       data_q,   data_d;
    logic                     done_q,   done_d;
    logic                     operr_q,  operr_d;
    logic                     oferr_q,  oferr_d;

    logic [3:0] nb_eff;
    logic       par_x;

    assign nb_eff = (i_nb_data < 4'd5 || i_nb_data > NB_MAX) ? NB_MAX : i_nb_data;
    assign par_x  = (^b_q) ^ rx_s;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        nb_d    = nb_q;
        pmode_d = pmode_q;
        stop2_d = stop2_q;
        stopn_d = stopn_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        operr_d = operr_q;
        oferr_d = oferr_q;

        if (i_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        s_d     = '0;
                        n_d     = '0;
                        b_d     = '0;
                        stopn_d = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        nb_d    = nb_eff;
                        pmode_d = parity_mode_e'(i_parity_mode);
                        stop2_d = i_stop2;
                    end
                end
                ST_START: begin
                    if (s_q == TICK_HALF) begin
                        s_d     = '0;
                        // Line back high at mid-start means it was a glitch
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (s_q == TICK_FULL) begin
                        s_d = '0;
                        b_d = b_q | ({{(NB_DATA-1){1'b0}}, rx_s} << n_q);
                        if (n_q == nb_q - 4'd1) begin
                            state_d = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 4'd1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (s_q == TICK_FULL) begin
                        s_d     = '0;
                        perr_d  = (pmode_q == PAR_EVEN) ? par_x : ~par_x;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (s_q == TICK_FULL) begin
                        s_d    = '0;
                        ferr_d = ferr_q | ~rx_s;
                        if (!stop2_q || stopn_q) begin
                            data_d  = b_q;
                            operr_d = perr_q;
                            oferr_d = ferr_q | ~rx_s;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            stopn_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            nb_q    <= '0;
            pmode_q <= PAR_NONE;
            stop2_q <= 1'b0;
            stopn_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            nb_q    <= nb_d;
            pmode_q <= pmode_d;
            stop2_q <= stop2_d;
            stopn_q <= stopn_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            operr_q <= operr_d;
            oferr_q <= oferr_d;
        end
    end

    assign o_data         = data_q;
    assign o_rx_done_tick = done_q;
    assign o_parity_err   = operr_q;
    assign o_frame_err    = oferr_q;
    assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomized frames for uart_rx_cfg, checked against a frame-level model.
module tb_uart_rx_cfg;

    localparam int NB_DATA = 8;
    localparam int N_TICKS = 16;

    logic               i_clock;
    logic               i_reset;
    logic               i_tick;
    logic               i_rx;
    logic [3:0]         i_nb_data;
    logic [1:0]         i_parity_mode;
    logic               i_stop2;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done_tick;
    logic               o_parity_err;
    logic               o_frame_err;
    logic               o_busy;

    typedef struct {
        logic [NB_DATA-1:0] d;
        logic               pe;
        logic               fe;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t last_exp;
    bit   have_last = 0;

    int total = 0;
    int bad   = 0;
    int tick_div = 1;
    int tcnt = 0;

    uart_rx_cfg #(.NB_DATA(NB_DATA), .N_TICKS(N_TICKS), .NB_TICK_COUNT(5)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_tick         (i_tick),
        .i_rx           (i_rx),
        .i_nb_data      (i_nb_data),
        .i_parity_mode  (i_parity_mode),
        .i_stop2        (i_stop2),
        .o_data         (o_data),
        .o_rx_done_tick (o_rx_done_tick),
        .o_parity_err   (o_parity_err),
        .o_frame_err    (o_frame_err),
        .o_busy         (o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Tick source: one tick every tick_div clocks
    initial begin
        i_tick = 1'b1;
        forever begin
            @(posedge i_clock);
            #1;
            if (tick_div <= 1) begin
                i_tick = 1'b1;
            end else begin
                tcnt   = (tcnt + 1) % tick_div;
                i_tick = (tcnt == 0);
            end
        end
    end

    always @(negedge i_clock) begin
        if (i_reset === 1'b1 && o_rx_done_tick === 1'b1)
            obs_q.push_back('{d: o_data, pe: o_parity_err, fe: o_frame_err});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [8:0] data, input int nb_cfg, input logic [1:0] pm,
                              input logic st2, input logic pbit, input logic sb1,
                              input logic sb2, input bit scramble);
        int   nbe;
        int   ones;
        int   bitclk;
        logic bits[$];
        rec_t e;
        nbe    = (nb_cfg < 5 || nb_cfg > NB_DATA) ? NB_DATA : nb_cfg;
        bitclk = N_TICKS * tick_div;
        bits.push_back(1'b0);
        for (int i = 0; i < nbe; i++) bits.push_back(data[i]);
        if (pm == 2'b01 || pm == 2'b10) bits.push_back(pbit);
        bits.push_back(sb1);
        if (st2) bits.push_back(sb2);

        e.d  = NB_DATA'(32'(data) & ((1 << nbe) - 1));
        ones = $countones(e.d) + int'(pbit);
        e.pe = (pm == 2'b01) ? (ones % 2 == 1) : (pm == 2'b10) ? (ones % 2 == 0) : 1'b0;
        e.fe = !sb1 || (st2 && !sb2);
        exp_q.push_back(e);

        i_nb_data     = 4'(nb_cfg);
        i_parity_mode = pm;
        i_stop2       = st2;
        for (int k = 0; k < bits.size(); k++) begin
            i_rx = bits[k];
            hold(bitclk);
            if (k == 0 && scramble) begin
                i_nb_data     = 4'($urandom);
                i_parity_mode = 2'($urandom);
                i_stop2       = 1'($urandom);
            end
        end
    endtask

    task automatic idle_gap();
        i_rx = 1'b1;
        hold(2 * N_TICKS * tick_div + 8);
    endtask

    task automatic flush_check(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_t o;
            rec_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(o.d), 32'(e.d));
            check({tag, "_perr"}, 32'(o.pe), 32'(e.pe));
            check({tag, "_ferr"}, 32'(o.fe), 32'(e.fe));
            last_exp  = e;
            have_last = 1;
        end
        exp_q.delete();
        obs_q.delete();
        if (have_last) begin
            check({tag, "_hold_data"}, 32'(o_data), 32'(last_exp.d));
            check({tag, "_hold_ferr"}, 32'(o_frame_err), 32'(last_exp.fe));
        end
    endtask

    initial begin
        int w;
        i_reset       = 1'b0;
        i_rx          = 1'b0;
        i_nb_data     = 4'd8;
        i_parity_mode = 2'b00;
        i_stop2       = 1'b0;
        hold(4);
        check("rst_data", 32'(o_data), 0);
        check("rst_done", 32'(o_rx_done_tick), 0);
        check("rst_perr", 32'(o_parity_err), 0);
        check("rst_ferr", 32'(o_frame_err), 0);
        check("rst_busy", 32'(o_busy), 0);
        i_rx = 1'b1;
        hold(4);
        i_reset = 1'b1;
        hold(8);

        send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        idle_gap();
        flush_check("8n1_a5");

        send_frame(9'h03C, 8, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        idle_gap();
        flush_check("8e1_p1");
        check("8e1_p1_flag", 32'(o_parity_err), 1);
        send_frame(9'h03C, 8, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        idle_gap();
        flush_check("8e1_p0");
        check("8e1_p0_flag", 32'(o_parity_err), 0);

        send_frame(9'h055, 7, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        idle_gap();
        flush_check("7o2_stoplow");
        check("7o2_ferr_flag", 32'(o_frame_err), 1);

        i_rx = 1'b0;
        hold(4);
        check("glitch_busy_hi", 32'(o_busy), 1);
        i_rx = 1'b1;
        w = 0;
        while (o_busy !== 1'b0 && w < 11) begin
            hold(1);
            w++;
        end
        check("glitch_busy_lo", 32'(o_busy), 0);
        hold(40);
        flush_check("glitch");

        send_frame(9'h012, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send_frame(9'h034, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        idle_gap();
        flush_check("b2b");

        i_nb_data     = 4'd8;
        i_parity_mode = 2'b00;
        i_stop2       = 1'b0;
        i_rx = 1'b0; hold(N_TICKS);
        i_rx = 1'b1; hold(N_TICKS);
        i_rx = 1'b0; hold(N_TICKS);
        i_rx = 1'b1; hold(N_TICKS / 2);
        check("mid_busy", 32'(o_busy), 1);
        i_reset = 1'b0;
        hold(2);
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_data", 32'(o_data), 0);
        check("mid_rst_done", 32'(o_rx_done_tick), 0);
        hold(2);
        i_reset = 1'b1;
        hold(4);
        have_last = 0;
        send_frame(9'h081, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        idle_gap();
        flush_check("rst_resume");

        for (int r = 0; r < 10; r++) begin
            int         nbc;
            logic [8:0] d;
            tick_div = $urandom_range(1, 3);
            hold(4);
            d = 9'($urandom);
            if ($urandom_range(0, 3) == 0) nbc = $urandom_range(0, 15);
            else nbc = $urandom_range(5, NB_DATA);
            send_frame(d, nbc, 2'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0), 1);
            idle_gap();
            flush_check("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
